// File: rtl/clock_ctrl_pkg.sv
// Shared types and constants for the alarm clock mode controller.
package clock_ctrl_pkg;

   typedef enum logic [2:0] {
      RUN         = 3'd0,
      SET_TIME_H  = 3'd1,
      SET_TIME_M  = 3'd2,
      SET_ALARM_H = 3'd3,
      SET_ALARM_M = 3'd4
   } mode_t;

   localparam int unsigned TIME_W = 8;
   localparam int unsigned BTN_W  = 4;

   localparam logic [TIME_W-1:0] HOURS_MAX = TIME_W'(23);
   localparam logic [TIME_W-1:0] MINS_MAX  = TIME_W'(59);
   localparam logic [TIME_W-1:0] SECS_MAX  = TIME_W'(59);

   // Bit positions within the debounced button vector
   localparam int unsigned BTN_MODE   = 0;
   localparam int unsigned BTN_INC_H  = 1;
   localparam int unsigned BTN_INC_M  = 2;
   localparam int unsigned BTN_ALM_EN = 3;

   function automatic logic [TIME_W-1:0] wrap_inc(input logic [TIME_W-1:0] v,
                                                  input logic [TIME_W-1:0] max);
      return (v >= max) ? TIME_W'(0) : v + TIME_W'(1);
   endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Rising-edge detector over a vector of debounced button levels.
module btn_edge_detect #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] level,
   output logic [WIDTH-1:0] rise_c
);

   logic [WIDTH-1:0] prev_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) prev_q <= '0;
      else       prev_q <= level;
   end

   assign rise_c = level & ~prev_q;

endmodule

// File: rtl/clock_mode_controller.sv
// Alarm clock sequencer: timekeeping, alarm, button-driven set modes and display select.
module clock_mode_controller
   import clock_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_S = 10,
   parameter int unsigned RING_S    = 60
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              tick_1hz,
   input  logic              btn_mode,
   input  logic              btn_inc_hours,
   input  logic              btn_inc_mins,
   input  logic              btn_alarm_en,
   output logic [TIME_W-1:0] cur_hours,
   output logic [TIME_W-1:0] cur_mins,
   output logic [TIME_W-1:0] cur_secs,
   output logic [TIME_W-1:0] alarm_hours,
   output logic [TIME_W-1:0] alarm_mins,
   output logic              alarm_en,
   output logic              alarm_ring,
   output logic [2:0]        mode,
   output logic [TIME_W-1:0] disp_hours,
   output logic [TIME_W-1:0] disp_mins
);

   localparam int unsigned TO_W   = $clog2(TIMEOUT_S + 1);
   localparam int unsigned RING_W = $clog2(RING_S + 1);

   logic [BTN_W-1:0] btn_level;
   logic [BTN_W-1:0] rise;
   logic             any_edge;
   logic             consumed;
   logic             running;
   logic             trig;

   mode_t             mode_q, mode_d;
   logic [TIME_W-1:0] hours_q, hours_d, mins_q, mins_d, secs_q, secs_d;
   logic [TIME_W-1:0] alm_h_q, alm_h_d, alm_m_q, alm_m_d;
   logic              alm_en_q, alm_en_d;
   logic              ring_q, ring_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic [RING_W-1:0] ring_cnt_q, ring_cnt_d;

   assign btn_level = {btn_alarm_en, btn_inc_mins, btn_inc_hours, btn_mode};

   btn_edge_detect #(.WIDTH(BTN_W)) u_edge (
      .clk    (clk),
      .reset  (reset),
      .level  (btn_level),
      .rise_c (rise)
   );

   assign any_edge = |rise;
   assign consumed = ring_q & any_edge;
   assign running  = (mode_q != SET_TIME_H) && (mode_q != SET_TIME_M);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_q     <= RUN;
         hours_q    <= '0;
         mins_q     <= '0;
         secs_q     <= '0;
         alm_h_q    <= '0;
         alm_m_q    <= '0;
         alm_en_q   <= 1'b0;
         ring_q     <= 1'b0;
         to_cnt_q   <= '0;
         ring_cnt_q <= '0;
      end else begin
         mode_q     <= mode_d;
         hours_q    <= hours_d;
         mins_q     <= mins_d;
         secs_q     <= secs_d;
         alm_h_q    <= alm_h_d;
         alm_m_q    <= alm_m_d;
         alm_en_q   <= alm_en_d;
         ring_q     <= ring_d;
         to_cnt_q   <= to_cnt_d;
         ring_cnt_q <= ring_cnt_d;
      end
   end

   always_comb begin
      mode_d     = mode_q;
      hours_d    = hours_q;
      mins_d     = mins_q;
      secs_d     = secs_q;
      alm_h_d    = alm_h_q;
      alm_m_d    = alm_m_q;
      alm_en_d   = alm_en_q;
      ring_d     = ring_q;
      to_cnt_d   = to_cnt_q;
      ring_cnt_d = ring_cnt_q;
      trig       = 1'b0;

      // Timekeeping with carry chain; trigger compares the post-increment time
      if (tick_1hz && running) begin
         secs_d = wrap_inc(secs_q, SECS_MAX);
         if (secs_q == SECS_MAX) begin
            mins_d = wrap_inc(mins_q, MINS_MAX);
            if (mins_q == MINS_MAX) hours_d = wrap_inc(hours_q, HOURS_MAX);
         end
         trig = alm_en_q && (hours_d == alm_h_q) && (mins_d == alm_m_q) &&
                (secs_d == TIME_W'(0));
      end

      // Button actions; an edge that dismisses the ring does nothing else
      if (!consumed) begin
         unique case (mode_q)
            RUN: begin
               if (rise[BTN_ALM_EN]) alm_en_d = ~alm_en_q;
               if (rise[BTN_MODE]) begin
                  mode_d = SET_TIME_H;
                  secs_d = '0;
               end
            end
            SET_TIME_H: begin
               if (rise[BTN_INC_H])     hours_d = wrap_inc(hours_q, HOURS_MAX);
               else if (rise[BTN_MODE]) mode_d  = SET_TIME_M;
            end
            SET_TIME_M: begin
               if (rise[BTN_INC_M])     mins_d = wrap_inc(mins_q, MINS_MAX);
               else if (rise[BTN_MODE]) mode_d = SET_ALARM_H;
            end
            SET_ALARM_H: begin
               if (rise[BTN_INC_H])     alm_h_d = wrap_inc(alm_h_q, HOURS_MAX);
               else if (rise[BTN_MODE]) mode_d  = SET_ALARM_M;
            end
            SET_ALARM_M: begin
               if (rise[BTN_INC_M])     alm_m_d = wrap_inc(alm_m_q, MINS_MAX);
               else if (rise[BTN_MODE]) mode_d  = RUN;
            end
            default: mode_d = RUN;
         endcase
      end

      // Inactivity timeout in set modes
      if (mode_q == RUN || any_edge) begin
         to_cnt_d = '0;
      end else if (tick_1hz) begin
         if ((32'(to_cnt_q) + 32'd1) >= TIMEOUT_S) begin
            mode_d   = RUN;
            to_cnt_d = '0;
         end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
         end
      end

      // Ring dismiss, auto-clear and trigger
      if (consumed) begin
         ring_d     = 1'b0;
         ring_cnt_d = '0;
      end else if (ring_q && tick_1hz) begin
         if ((32'(ring_cnt_q) + 32'd1) >= RING_S) begin
            ring_d     = 1'b0;
            ring_cnt_d = '0;
         end else begin
            ring_cnt_d = ring_cnt_q + RING_W'(1);
         end
      end
      if (trig) begin
         ring_d     = 1'b1;
         ring_cnt_d = '0;
      end
      if (!alm_en_d) ring_d = 1'b0;
   end

   assign cur_hours   = hours_q;
   assign cur_mins    = mins_q;
   assign cur_secs    = secs_q;
   assign alarm_hours = alm_h_q;
   assign alarm_mins  = alm_m_q;
   assign alarm_en    = alm_en_q;
   assign alarm_ring  = ring_q;
   assign mode        = mode_q;

   always_comb begin
      disp_hours = hours_q;
      disp_mins  = mins_q;
      if (mode_q == SET_ALARM_H || mode_q == SET_ALARM_M) begin
         disp_hours = alm_h_q;
         disp_mins  = alm_m_q;
      end
   end

endmodule

// File: tb/tb_clock_mode_controller.sv
// Scoreboard bench for clock_mode_controller: directed button/tick sequences.
module tb_clock_mode_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tick_1hz = 1'b0;
   logic       btn_mode = 1'b0, btn_inc_hours = 1'b0, btn_inc_mins = 1'b0, btn_alarm_en = 1'b0;
   logic [7:0] cur_hours, cur_mins, cur_secs, alarm_hours, alarm_mins, disp_hours, disp_mins;
   logic       alarm_en, alarm_ring;
   logic [2:0] mode;

   clock_mode_controller #(.TIMEOUT_S(10), .RING_S(60)) dut (
      .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
      .btn_mode(btn_mode), .btn_inc_hours(btn_inc_hours),
      .btn_inc_mins(btn_inc_mins), .btn_alarm_en(btn_alarm_en),
      .cur_hours(cur_hours), .cur_mins(cur_mins), .cur_secs(cur_secs),
      .alarm_hours(alarm_hours), .alarm_mins(alarm_mins),
      .alarm_en(alarm_en), .alarm_ring(alarm_ring), .mode(mode),
      .disp_hours(disp_hours), .disp_mins(disp_mins)
   );

   always #5 clk = ~clk;

   localparam int S_H = 0, S_M = 1, S_S = 2, S_AH = 3, S_AM = 4,
                  S_EN = 5, S_RING = 6, S_MODE = 7, S_DH = 8, S_DM = 9;
   localparam logic [3:0] B_MODE = 4'b0001, B_H = 4'b0010, B_M = 4'b0100, B_EN = 4'b1000;

   string q_name[$];
   int    q_sel[$];
   int    q_val[$];
   int    checks = 0;
   int    failures = 0;

   function automatic int actual(input int sel);
      case (sel)
         S_H:    return int'(cur_hours);
         S_M:    return int'(cur_mins);
         S_S:    return int'(cur_secs);
         S_AH:   return int'(alarm_hours);
         S_AM:   return int'(alarm_mins);
         S_EN:   return int'(alarm_en);
         S_RING: return int'(alarm_ring);
         S_MODE: return int'(mode);
         S_DH:   return int'(disp_hours);
         default: return int'(disp_mins);
      endcase
   endfunction

   task automatic expect_eq(input string name, input int sel, input int val);
      q_name.push_back(name);
      q_sel.push_back(sel);
      q_val.push_back(val);
   endtask

   // Monitor: drain pending expectations mid-cycle, away from the active edge
   always @(negedge clk) begin
      while (q_sel.size() != 0) begin
         automatic string n = q_name.pop_front();
         automatic int    s = q_sel.pop_front();
         automatic int    v = q_val.pop_front();
         automatic int    a = actual(s);
         checks++;
         if (a !== v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, a, v, $time);
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [3:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         {btn_alarm_en, btn_inc_mins, btn_inc_hours, btn_mode} = b;
         cyc(1);
         {btn_alarm_en, btn_inc_mins, btn_inc_hours, btn_mode} = 4'b0000;
         cyc(1);
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         tick_1hz = 1'b1;
         cyc(1);
         tick_1hz = 1'b0;
         if (i != n - 1) cyc(1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      cyc(2);
      reset = 1'b0;
      cyc(1);
      expect_eq("reset_mode", S_MODE, 0);
      expect_eq("reset_hours", S_H, 0);
      expect_eq("reset_mins", S_M, 0);
      expect_eq("reset_secs", S_S, 0);
      expect_eq("reset_alarm_en", S_EN, 0);
      expect_eq("reset_ring", S_RING, 0);

      // Basic time entry with minute wrap and no hour carry
      press(B_MODE, 1);
      expect_eq("enter_set_time_h", S_MODE, 1);
      press(B_H, 5);
      press(B_MODE, 1);
      press(B_M, 61);
      press(B_MODE, 1);
      expect_eq("entry_hours", S_H, 5);
      expect_eq("entry_mins_wrap", S_M, 1);
      expect_eq("entry_mode", S_MODE, 3);
      expect_eq("disp_alarm_h", S_DH, 0);

      // Alarm 07:30, back to RUN
      press(B_H, 7);
      press(B_MODE, 1);
      press(B_M, 30);
      expect_eq("disp_alarm_m", S_DM, 30);
      press(B_MODE, 1);
      expect_eq("alarm_hours", S_AH, 7);
      expect_eq("alarm_mins", S_AM, 30);
      expect_eq("run_mode", S_MODE, 0);
      expect_eq("disp_run_m", S_DM, 1);

      // Rollover from 23:59
      press(B_MODE, 1);
      ticks(1);
      expect_eq("frozen_secs", S_S, 0);
      press(B_H, 18);
      press(B_MODE, 1);
      press(B_M, 58);
      press(B_MODE, 3);
      expect_eq("pre_roll_h", S_H, 23);
      expect_eq("pre_roll_m", S_M, 59);
      ticks(1);
      expect_eq("first_tick_secs", S_S, 1);
      ticks(59);
      expect_eq("roll_h", S_H, 0);
      expect_eq("roll_m", S_M, 0);
      expect_eq("roll_s", S_S, 0);

      // Set 07:29:00, arm alarm, run to 07:29:58
      press(B_MODE, 1);
      press(B_H, 7);
      press(B_MODE, 1);
      press(B_M, 29);
      press(B_MODE, 3);
      press(B_EN, 1);
      expect_eq("alarm_armed", S_EN, 1);
      ticks(58);
      expect_eq("pre_alarm_secs", S_S, 58);
      ticks(1);
      expect_eq("no_ring_early", S_RING, 0);
      ticks(1);
      expect_eq("ring_set", S_RING, 1);
      expect_eq("ring_time_m", S_M, 30);

      // Dismiss: edge consumed
      press(B_M, 1);
      expect_eq("dismiss_ring", S_RING, 0);
      expect_eq("dismiss_mins", S_M, 30);
      expect_eq("dismiss_mode", S_MODE, 0);
      expect_eq("dismiss_alarm_m", S_AM, 30);

      // Ring auto-clear: alarm to 07:31, entering SET_TIME_H zeroes secs
      press(B_MODE, 4);
      press(B_M, 1);
      press(B_MODE, 1);
      expect_eq("alarm_m_31", S_AM, 31);
      ticks(60);
      expect_eq("ring2_set", S_RING, 1);
      ticks(59);
      expect_eq("ring2_held", S_RING, 1);
      ticks(1);
      expect_eq("ring2_timeout", S_RING, 0);
      expect_eq("ring2_en_kept", S_EN, 1);

      // Mode timeout in SET_ALARM_M
      press(B_MODE, 4);
      ticks(9);
      expect_eq("to_mode_9", S_MODE, 4);
      press(B_M, 1);
      ticks(9);
      expect_eq("to_mode_after_edge", S_MODE, 4);
      ticks(1);
      expect_eq("to_mode_run", S_MODE, 0);
      expect_eq("to_alarm_m", S_AM, 32);
      expect_eq("to_secs", S_S, 19);

      // Simultaneous edges, held button, alarm toggle ignored in set mode
      press(B_MODE, 1);
      press(B_MODE | B_H, 1);
      expect_eq("simul_hours", S_H, 8);
      expect_eq("simul_mode", S_MODE, 1);
      btn_inc_hours = 1'b1;
      cyc(20);
      btn_inc_hours = 1'b0;
      cyc(1);
      expect_eq("held_hours", S_H, 9);
      expect_eq("disp_set_h", S_DH, 9);
      press(B_EN, 1);
      expect_eq("en_ignored", S_EN, 1);

      // Async reset in SET_TIME_M, button held through release
      press(B_MODE, 1);
      expect_eq("pre_reset_mode", S_MODE, 2);
      @(posedge clk);
      #1;
      btn_mode = 1'b1;
      reset = 1'b1;
      #1;
      expect_eq("async_mode", S_MODE, 0);
      expect_eq("async_hours", S_H, 0);
      expect_eq("async_alarm_m", S_AM, 0);
      expect_eq("async_en", S_EN, 0);
      expect_eq("async_disp_h", S_DH, 0);
      cyc(2);
      reset = 1'b0;
      cyc(1);
      expect_eq("held_through_reset", S_MODE, 1);
      btn_mode = 1'b0;
      cyc(2);
      expect_eq("held_single_edge", S_MODE, 1);

      cyc(2);
      if (q_sel.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending expected 0", q_sel.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
